// File: rtl/snn_load_pkg.sv
// Shared types and constants for the SNN core load path: sequencer state,
// grid write widths and the special next_core codes.
package snn_load_pkg;

  localparam int PARAM_W = 368;
  localparam int INST_W  = 2;

  localparam logic [2:0] CORE_IDLE     = 3'd7;
  localparam logic [2:0] CORE_ALL_DONE = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_PARAM = 3'd1,
    ST_LOAD_INST  = 3'd2,
    ST_WAIT_EN    = 3'd3,
    ST_DONE       = 3'd4,
    ST_ERROR      = 3'd5
  } load_state_t;

endpackage

// File: rtl/core_load_sequencer_if.sv
// Control, upstream stream and grid write signals of the core load sequencer.
// slave = sequencer side, master = upstream/grid side.
interface core_load_sequencer_if;
  import snn_load_pkg::*;

  logic               start;
  logic               abort;
  logic               param_valid;
  logic [PARAM_W-1:0] param_data;
  logic               param_ready;
  logic               inst_valid;
  logic [INST_W-1:0]  inst_data;
  logic               inst_ready;
  logic               next_core_en;
  logic [2:0]         next_core;
  logic [PARAM_W-1:0] parameter_in;
  logic               param_winc;
  logic [INST_W-1:0]  neuron_inst_wdata;
  logic               neuron_inst_winc;
  logic               busy;
  logic               done;
  logic               error;

  modport slave (
    input  start, abort,
    input  param_valid, param_data,
    output param_ready,
    input  inst_valid, inst_data,
    output inst_ready,
    input  next_core_en,
    output next_core,
    output parameter_in, param_winc,
    output neuron_inst_wdata, neuron_inst_winc,
    output busy, done, error
  );

  modport master (
    output start, abort,
    output param_valid, param_data,
    input  param_ready,
    output inst_valid, inst_data,
    input  inst_ready,
    output next_core_en,
    input  next_core,
    input  parameter_in, param_winc,
    input  neuron_inst_wdata, neuron_inst_winc,
    input  busy, done, error
  );

endinterface

// File: rtl/load_timeout_cnt.sv
// Saturating wait counter: cleared while clear is high, counts while enable is
// high, and flags expired once it has counted TIMEOUT cycles.
module load_timeout_cnt #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign expired = (count_reg == CW'(TIMEOUT));

endmodule

// File: rtl/core_load_sequencer.sv
// Streams NUM_NEURONS parameter words then NUM_NEURONS instructions into each
// grid core in turn, waiting for the grid acknowledge between cores.
module core_load_sequencer
  import snn_load_pkg::*;
#(
  parameter int NUM_CORES   = 6,
  parameter int NUM_NEURONS = 256,
  parameter int TIMEOUT     = 1023
) (
  input logic                  clk,
  input logic                  reset,
  core_load_sequencer_if.slave bus
);

  localparam int WCW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  load_state_t        state_reg, state_next;
  logic [WCW-1:0]     word_cnt_reg, word_cnt_next;
  logic [2:0]         core_cnt_reg, core_cnt_next;

  logic               param_ready_c;
  logic               inst_ready_c;
  logic               param_xfer;
  logic               inst_xfer;
  logic               last_word;
  logic               last_core;
  logic               wait_expired;

  logic [PARAM_W-1:0] parameter_in_reg;
  logic               param_winc_reg;
  logic [INST_W-1:0]  inst_wdata_reg;
  logic               inst_winc_reg;

  logic [2:0]         next_core_c;
  logic               busy_c;
  logic               done_c;
  logic               error_c;

  assign last_word  = (word_cnt_reg == WCW'(NUM_NEURONS - 1));
  assign last_core  = (core_cnt_reg == 3'(NUM_CORES - 1));
  assign param_xfer = bus.param_valid & param_ready_c;
  assign inst_xfer  = bus.inst_valid & inst_ready_c;

  // Counter runs only inside WAIT_EN, so it is already zero on every entry.
  load_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_reg != ST_WAIT_EN),
    .enable  (state_reg == ST_WAIT_EN),
    .expired (wait_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      word_cnt_reg <= '0;
      core_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      word_cnt_reg <= word_cnt_next;
      core_cnt_reg <= core_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    word_cnt_next = word_cnt_reg;
    core_cnt_next = core_cnt_reg;
    param_ready_c = 1'b0;
    inst_ready_c  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          state_next    = ST_LOAD_PARAM;
          word_cnt_next = '0;
          core_cnt_next = '0;
        end
      end
      ST_LOAD_PARAM: begin
        param_ready_c = 1'b1;
        if (bus.param_valid) begin
          if (last_word) begin
            word_cnt_next = '0;
            state_next    = ST_LOAD_INST;
          end else begin
            word_cnt_next = word_cnt_reg + WCW'(1);
          end
        end
      end
      ST_LOAD_INST: begin
        inst_ready_c = 1'b1;
        if (bus.inst_valid) begin
          if (last_word) begin
            word_cnt_next = '0;
            state_next    = last_core ? ST_DONE : ST_WAIT_EN;
          end else begin
            word_cnt_next = word_cnt_reg + WCW'(1);
          end
        end
      end
      ST_WAIT_EN: begin
        // An acknowledge arriving in the expiry cycle still wins.
        if (bus.next_core_en) begin
          core_cnt_next = core_cnt_reg + 3'd1;
          word_cnt_next = '0;
          state_next    = ST_LOAD_PARAM;
        end else if (wait_expired) begin
          state_next = ST_ERROR;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          state_next    = ST_LOAD_PARAM;
          word_cnt_next = '0;
          core_cnt_next = '0;
        end
      end
      ST_ERROR: begin
        state_next = ST_ERROR;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Abort overrides everything; ready is withdrawn so nothing is consumed.
    if (bus.abort) begin
      state_next    = ST_IDLE;
      word_cnt_next = '0;
      core_cnt_next = '0;
      param_ready_c = 1'b0;
      inst_ready_c  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parameter_in_reg <= '0;
      param_winc_reg   <= 1'b0;
      inst_wdata_reg   <= '0;
      inst_winc_reg    <= 1'b0;
    end else begin
      param_winc_reg <= param_xfer;
      inst_winc_reg  <= inst_xfer;
      if (param_xfer) begin
        parameter_in_reg <= bus.param_data;
      end
      if (inst_xfer) begin
        inst_wdata_reg <= bus.inst_data;
      end
    end
  end

  always_comb begin
    next_core_c = CORE_IDLE;
    busy_c      = 1'b0;
    done_c      = 1'b0;
    error_c     = 1'b0;
    case (state_reg)
      ST_LOAD_PARAM,
      ST_LOAD_INST,
      ST_WAIT_EN: begin
        next_core_c = core_cnt_reg;
        busy_c      = 1'b1;
      end
      ST_DONE: begin
        next_core_c = CORE_ALL_DONE;
        done_c      = 1'b1;
      end
      ST_ERROR: begin
        error_c = 1'b1;
      end
      default: begin
        next_core_c = CORE_IDLE;
      end
    endcase
  end

  assign bus.param_ready       = param_ready_c;
  assign bus.inst_ready        = inst_ready_c;
  assign bus.next_core         = next_core_c;
  assign bus.parameter_in      = parameter_in_reg;
  assign bus.param_winc        = param_winc_reg;
  assign bus.neuron_inst_wdata = inst_wdata_reg;
  assign bus.neuron_inst_winc  = inst_winc_reg;
  assign bus.busy              = busy_c;
  assign bus.done              = done_c;
  assign bus.error             = error_c;

endmodule

// File: tb/tb_core_load_sequencer.sv
// Scoreboard bench for core_load_sequencer: accepted words are queued as they
// are driven and matched against the grid write strobes as they appear.
module tb_core_load_sequencer;
  import snn_load_pkg::*;

  localparam int NC = 6;
  localparam int NN = 256;
  localparam int TO = 1023;

  typedef logic [PARAM_W-1:0] word_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  core_load_sequencer_if bus_if();

  core_load_sequencer #(
    .NUM_CORES   (NC),
    .NUM_NEURONS (NN),
    .TIMEOUT     (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int total = 0;
  int bad   = 0;
  int p_cnt = 0;
  int i_cnt = 0;
  word_t             p_q[$];
  logic [INST_W-1:0] i_q[$];
  bit poke_start = 1'b0;
  bit poke_en    = 1'b0;

  task automatic check(input string tag, input word_t got, input word_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Strobe monitor: every write must match the oldest accepted word.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus_if.param_winc === 1'b1) begin
        p_cnt++;
        if (p_q.size() == 0) check("p_extra", word_t'(1), word_t'(0));
        else check("p_data", bus_if.parameter_in, p_q.pop_front());
      end
      if (bus_if.neuron_inst_winc === 1'b1) begin
        i_cnt++;
        if (i_q.size() == 0) check("i_extra", word_t'(1), word_t'(0));
        else check("i_data", word_t'(bus_if.neuron_inst_wdata), word_t'(i_q.pop_front()));
      end
    end
  end

  task automatic send_stream(input bit is_inst, input int c, input int gap, input int nwords);
    int w = 0;
    int guard = 0;
    word_t pd;
    while (w < nwords) begin
      @(negedge clk);
      bus_if.start        = poke_start && (w == 10);
      bus_if.next_core_en = poke_en && (w == 5);
      if (gap > 0 && int'($urandom_range(99)) < gap) begin
        if (is_inst) bus_if.inst_valid = 1'b0;
        else bus_if.param_valid = 1'b0;
      end else if (is_inst) begin
        bus_if.inst_data  = INST_W'($urandom);
        bus_if.inst_valid = 1'b1;
      end else begin
        pd = '0;
        for (int k = 0; k < 11; k++) pd[k*32 +: 32] = $urandom;
        pd[PARAM_W-1 -: 16] = 16'(w);
        pd[PARAM_W-17 -: 8] = 8'(c);
        bus_if.param_data  = pd;
        bus_if.param_valid = 1'b1;
      end
      #1;
      if (is_inst && bus_if.inst_valid && bus_if.inst_ready) begin
        if (w == 0) check("i_core", word_t'(bus_if.next_core), word_t'(c));
        i_q.push_back(bus_if.inst_data);
        w++;
      end else if (!is_inst && bus_if.param_valid && bus_if.param_ready) begin
        if (w == 0) check("p_core", word_t'(bus_if.next_core), word_t'(c));
        p_q.push_back(bus_if.param_data);
        w++;
      end
      guard++;
      if (guard > NN * 50) begin
        check("stall", word_t'(0), word_t'(1));
        return;
      end
    end
  endtask

  task automatic ack_core(input int c);
    @(negedge clk);
    check("w_busy", word_t'(bus_if.busy), word_t'(1));
    check("w_core", word_t'(bus_if.next_core), word_t'(c));
    check("w_rdy", word_t'({bus_if.param_ready, bus_if.inst_ready}), word_t'(0));
    @(negedge clk);
    bus_if.next_core_en = 1'b1;
  endtask

  task automatic begin_load();
    @(negedge clk);
    bus_if.start = 1'b1;
    p_cnt = 0;
    i_cnt = 0;
  endtask

  task automatic drop_valids();
    bus_if.param_valid  = 1'b0;
    bus_if.inst_valid   = 1'b0;
    bus_if.start        = 1'b0;
    bus_if.next_core_en = 1'b0;
  endtask

  task automatic run_load(input int gap);
    begin_load();
    for (int c = 0; c < NC; c++) begin
      send_stream(1'b0, c, gap, NN);
      send_stream(1'b1, c, gap, NN);
      if (c < NC - 1) ack_core(c);
    end
    @(negedge clk);
    check("d_done", word_t'(bus_if.done), word_t'(1));
    check("d_core", word_t'(bus_if.next_core), word_t'(CORE_ALL_DONE));
    check("d_busy", word_t'(bus_if.busy), word_t'(0));
    check("d_pcnt", word_t'(p_cnt), word_t'(NC * NN));
    check("d_icnt", word_t'(i_cnt), word_t'(NC * NN));
    check("d_qlen", word_t'(p_q.size() + i_q.size()), word_t'(0));
    drop_valids();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_core"}, word_t'(bus_if.next_core), word_t'(CORE_IDLE));
    check({tag, "_flags"}, word_t'({bus_if.busy, bus_if.done, bus_if.error}), word_t'(0));
    check({tag, "_winc"}, word_t'({bus_if.param_winc, bus_if.neuron_inst_winc}), word_t'(0));
    check({tag, "_rdy"}, word_t'({bus_if.param_ready, bus_if.inst_ready}), word_t'(0));
    check({tag, "_pin"}, bus_if.parameter_in, word_t'(0));
    check({tag, "_iwd"}, word_t'(bus_if.neuron_inst_wdata), word_t'(0));
  endtask

  initial begin
    #2_000_000;
    check("watchdog", word_t'(0), word_t'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int k;
    bus_if.abort = 1'b0;
    bus_if.param_data = '0;
    bus_if.inst_data = '0;
    drop_valids();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // Plain full load, then a second one started from DONE with gaps and
    // ignored start/next_core_en pokes while busy.
    run_load(0);
    $display("load nogap: pcnt=%0d icnt=%0d done=%0b", p_cnt, i_cnt, bus_if.done);
    poke_start = 1'b1;
    poke_en    = 1'b1;
    run_load(30);
    poke_start = 1'b0;
    poke_en    = 1'b0;
    $display("load gaps: pcnt=%0d icnt=%0d done=%0b", p_cnt, i_cnt, bus_if.done);

    // Abort together with start in the middle of core 3 instructions.
    begin_load();
    for (int c = 0; c < 3; c++) begin
      send_stream(1'b0, c, 0, NN);
      send_stream(1'b1, c, 0, NN);
      ack_core(c);
    end
    send_stream(1'b0, 3, 0, NN);
    send_stream(1'b1, 3, 0, 50);
    @(negedge clk);
    bus_if.abort = 1'b1;
    bus_if.start = 1'b1;
    #1;
    check("ab_rdy", word_t'({bus_if.param_ready, bus_if.inst_ready}), word_t'(0));
    @(negedge clk);
    bus_if.abort = 1'b0;
    bus_if.start = 1'b0;
    check("ab_core", word_t'(bus_if.next_core), word_t'(CORE_IDLE));
    check("ab_busy", word_t'(bus_if.busy), word_t'(0));
    repeat (20) @(negedge clk);
    check("ab_pcnt", word_t'(p_cnt), word_t'(4 * NN));
    check("ab_icnt", word_t'(i_cnt), word_t'(3 * NN + 50));
    $display("abort: pcnt=%0d icnt=%0d core=%0d", p_cnt, i_cnt, bus_if.next_core);
    drop_valids();

    // No acknowledge after core 0: ERROR after the wait budget.
    begin_load();
    send_stream(1'b0, 0, 10, NN);
    send_stream(1'b1, 0, 10, NN);
    k = -1;
    do begin
      @(negedge clk);
      k++;
    end while (!bus_if.error && k < TO + 20);
    check("to_cycles", word_t'(k), word_t'(TO + 1));
    check("to_core", word_t'(bus_if.next_core), word_t'(CORE_IDLE));
    check("to_busy", word_t'({bus_if.busy, bus_if.done}), word_t'(0));
    $display("timeout: cycles=%0d error=%0b", k, bus_if.error);
    drop_valids();
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    check("to_hold", word_t'(bus_if.error), word_t'(1));
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.abort = 1'b0;
    check("to_clr", word_t'({bus_if.error, bus_if.next_core}), word_t'({1'b0, CORE_IDLE}));

    // Asynchronous reset at word 100 of core 2, then a clean reload.
    begin_load();
    for (int c = 0; c < 2; c++) begin
      send_stream(1'b0, c, 0, NN);
      send_stream(1'b1, c, 0, NN);
      ack_core(c);
    end
    send_stream(1'b0, 2, 0, 100);
    #2;
    reset = 1'b1;
    p_q.delete();
    i_q.delete();
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    p_cnt = 0;
    i_cnt = 0;
    repeat (10) @(negedge clk);
    check("post_rst_strobes", word_t'(p_cnt + i_cnt), word_t'(0));
    drop_valids();
    run_load(20);
    $display("reload: pcnt=%0d icnt=%0d done=%0b", p_cnt, i_cnt, bus_if.done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
